uart_tx_scheduler: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Width of requester indices on cur_id / err_id / cfg_id.
  localparam int ID_W = 3;

  // Divisor the uart powers up with; the scheduler's table starts here too.
  localparam int UART_DEFAULT_DIV = 651;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first pending requester after ptr, wrapping mod N.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] sel,
  output logic            vld
);

  logic [ID_W-1:0] hi_sel;
  logic            hi_vld;
  logic [ID_W-1:0] lo_sel;

  // Scan downward so the last hit is the lowest index: hi_* tracks the lowest
  // set bit above ptr, lo_* the lowest set bit overall (used on wrap-around).
  always_comb begin
    hi_sel = '0;
    hi_vld = 1'b0;
    lo_sel = '0;
    vld    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld    = 1'b1;
        lo_sel = ID_W'(i);
        if (ID_W'(i) > ptr) begin
          hi_vld = 1'b1;
          hi_sel = ID_W'(i);
        end
      end
    end
    sel = hi_vld ? hi_sel : lo_sel;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart transmitter between N byte requesters, round-robin, per-requester baud.
// Latency: uart_start rises 1 clk after req is seen in IDLE; frames are separated by GAP_CYCLES.
// Backpressure: req is a level held until ack; only one frame in flight, watchdog aborts stuck frames.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N           = 4,
  parameter int DIV_W       = 32,
  parameter int DEFAULT_DIV = uart_pkg::UART_DEFAULT_DIV,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 200000
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     ack,
  input  logic             cfg_we,
  input  logic [ID_W-1:0]  cfg_id,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             uart_start,
  output logic [7:0]       uart_data,
  output logic [DIV_W-1:0] uart_divisor,
  input  logic             uart_tx_done,
  output logic             busy,
  output logic [ID_W-1:0]  cur_id,
  output logic             err,
  output logic [ID_W-1:0]  err_id
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  arb_sel;
  logic             arb_vld;
  logic             done_q;
  logic             done_edge;
  logic             timeout_hit;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic [DIV_W-1:0] div_tab [N];
  logic [7:0]       sel_data;
  logic [DIV_W-1:0] sel_div;
  logic [N-1:0]     sel_onehot;

  rr_arbiter #(.N(N)) u_arb (
    .req (req),
    .ptr (ptr),
    .sel (arb_sel),
    .vld (arb_vld)
  );

  // Only a fresh rising edge of tx_done completes a frame; a stale high level does not.
  assign done_edge   = uart_tx_done & ~done_q;
  assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));
  assign busy        = (state != ST_IDLE);

  // Gather the winner's byte, divisor and one-hot ack from the arbiter index.
  always_comb begin
    sel_data   = '0;
    sel_div    = '0;
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_sel == ID_W'(i)) begin
        sel_data      = req_data[8*i +: 8];
        sel_div       = div_tab[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Registered copy of tx_done for edge detection.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= uart_tx_done;
    end
  end

  // Divisor table: writes land in any state; a grant in the same cycle reads the old entry.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < N; i++) begin
        div_tab[i] <= DIV_W'(DEFAULT_DIV);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cfg_we && (cfg_id == ID_W'(i))) begin
          div_tab[i] <= cfg_div;
        end
      end
    end
  end

  // Frame sequencer: grant, hold the uart inputs through SEND, then the inter-frame gap.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state        <= ST_IDLE;
      ptr          <= ID_W'(N - 1);
      ack          <= '0;
      uart_start   <= 1'b0;
      uart_data    <= '0;
      uart_divisor <= DIV_W'(DEFAULT_DIV);
      cur_id       <= '0;
      err          <= 1'b0;
      err_id       <= '0;
      timer        <= '0;
      gap_cnt      <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            state        <= ST_SEND;
            uart_data    <= sel_data;
            uart_divisor <= sel_div;
            cur_id       <= arb_sel;
            ack          <= sel_onehot;
            uart_start   <= 1'b1;
            timer        <= '0;
          end
        end
        ST_SEND: begin
          timer <= timer + 1'b1;
          if (done_edge || timeout_hit) begin
            uart_start <= 1'b0;
            ptr        <= cur_id;
            // A completion in the same cycle as the timeout is not an abort.
            if (!done_edge) begin
              err    <= 1'b1;
              err_id <= cur_id;
            end
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of frames plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: the bench plays both the requesters and the uart.
module tb_uart_tx_scheduler;

  localparam int N       = 4;
  localparam int DIV_W   = 32;
  localparam int DEF_DIV = 651;

  logic             clk;
  logic             areset_n;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     ack;
  logic             cfg_we;
  logic [2:0]       cfg_id;
  logic [DIV_W-1:0] cfg_div;
  logic             uart_start;
  logic [7:0]       uart_data;
  logic [DIV_W-1:0] uart_divisor;
  logic             uart_tx_done;
  logic             busy;
  logic [2:0]       cur_id;
  logic             err;
  logic [2:0]       err_id;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_scheduler #(
    .N(N), .DIV_W(DIV_W), .DEFAULT_DIV(DEF_DIV), .GAP_CYCLES(2), .TIMEOUT(100)
  ) dut (
    .clk          (clk),
    .areset_n     (areset_n),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .cfg_we       (cfg_we),
    .cfg_id       (cfg_id),
    .cfg_div      (cfg_div),
    .uart_start   (uart_start),
    .uart_data    (uart_data),
    .uart_divisor (uart_divisor),
    .uart_tx_done (uart_tx_done),
    .busy         (busy),
    .cur_id       (cur_id),
    .err          (err),
    .err_id       (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         id;
    logic [7:0] data;
    int         dly;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One grant edge, then the uart-facing outputs of the new frame.
  task automatic grant_chk(input int id, input logic [7:0] data, input logic [31:0] div);
    tick();
    chk("grant_ack", 32'(ack), 32'(1) << id);
    chk("grant_start", 32'(uart_start), 32'd1);
    chk("grant_data", 32'(uart_data), 32'(data));
    chk("grant_div", uart_divisor, div);
    chk("grant_cur_id", 32'(cur_id), 32'(id));
    chk("grant_busy", 32'(busy), 32'd1);
  endtask

  // Uart model: tx_done rises after dly cycles; then check the two-cycle gap.
  task automatic finish_chk(input int dly);
    for (int i = 0; i < dly; i++) begin
      tick();
      if (i == 0) chk("ack_single_pulse", 32'(ack), 32'd0);
    end
    chk("start_held", 32'(uart_start), 32'd1);
    uart_tx_done = 1'b1;
    tick();
    chk("done_start_low", 32'(uart_start), 32'd0);
    chk("done_busy_gap", 32'(busy), 32'd1);
    uart_tx_done = 1'b0;
    tick();
    chk("gap_busy", 32'(busy), 32'd1);
    tick();
    chk("gap_end_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    tick();
    tick();
    areset_n = 1'b1;
  endtask

  initial begin
    areset_n     = 1'b0;
    req          = '0;
    req_data     = {8'h43, 8'h32, 8'h21, 8'h10};
    cfg_we       = 1'b0;
    cfg_id       = '0;
    cfg_div      = '0;
    uart_tx_done = 1'b0;

    vecs[0]  = '{4'b1111, 0, 8'h10, 3};
    vecs[1]  = '{4'b1111, 1, 8'h21, 4};
    vecs[2]  = '{4'b1111, 2, 8'h32, 5};
    vecs[3]  = '{4'b1111, 3, 8'h43, 3};
    vecs[4]  = '{4'b1111, 0, 8'h10, 4};
    vecs[5]  = '{4'b1010, 1, 8'h21, 3};
    vecs[6]  = '{4'b0001, 0, 8'h10, 5};
    vecs[7]  = '{4'b1000, 3, 8'h43, 3};
    vecs[8]  = '{4'b1001, 0, 8'h10, 4};
    vecs[9]  = '{4'b0110, 1, 8'h21, 3};
    vecs[10] = '{4'b0110, 2, 8'h32, 3};

    // Reset state
    tick();
    chk("rst_start", 32'(uart_start), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div", uart_divisor, 32'(DEF_DIV));
    chk("rst_data", 32'(uart_data), 32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_id", 32'(err_id), 32'd0);
    areset_n = 1'b1;
    tick();

    // Single request at a configured baud
    cfg_we = 1'b1; cfg_id = 3'd1; cfg_div = 32'd326;
    tick();
    cfg_we = 1'b0;
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    grant_chk(1, 8'hA5, 32'd326);
    req = '0;
    finish_chk(50);
    req_data[15:8] = 8'h21;

    // Fairness and wrap-around from a fresh reset
    do_reset();
    for (int v = 0; v < 11; v++) begin
      req = vecs[v].req;
      grant_chk(vecs[v].id, vecs[v].data, 32'(DEF_DIV));
      finish_chk(vecs[v].dly);
    end
    req = '0;

    // Watchdog abort on requester 2, then requester 0 served normally
    req = 4'b0100;
    grant_chk(2, 8'h32, 32'(DEF_DIV));
    req = 4'b0001;
    for (int i = 0; i < 99; i++) tick();
    chk("wd_start_before", 32'(uart_start), 32'd1);
    chk("wd_err_before", 32'(err), 32'd0);
    tick();
    chk("wd_start_drop", 32'(uart_start), 32'd0);
    chk("wd_err_pulse", 32'(err), 32'd1);
    chk("wd_err_id", 32'(err_id), 32'd2);
    tick();
    chk("wd_err_single", 32'(err), 32'd0);
    tick();
    chk("wd_idle", 32'(busy), 32'd0);
    grant_chk(0, 8'h10, 32'(DEF_DIV));
    req = '0;
    finish_chk(4);
    chk("wd_err_id_hold", 32'(err_id), 32'd2);

    // Stale tx_done level must not complete the frame
    uart_tx_done = 1'b1;
    tick();
    tick();
    req = 4'b0001;
    grant_chk(0, 8'h10, 32'(DEF_DIV));
    req = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("stale_start_held", 32'(uart_start), 32'd1);
    chk("stale_busy", 32'(busy), 32'd1);
    uart_tx_done = 1'b0;
    finish_chk(2);

    // Config write racing a grant to the same id; write during SEND is deferred
    req = 4'b0001;
    cfg_we = 1'b1; cfg_id = 3'd0; cfg_div = 32'd100;
    grant_chk(0, 8'h10, 32'(DEF_DIV));
    cfg_we = 1'b0;
    finish_chk(3);
    grant_chk(0, 8'h10, 32'd100);
    req = '0;
    cfg_we = 1'b1; cfg_id = 3'd0; cfg_div = 32'd200;
    tick();
    cfg_we = 1'b0;
    chk("send_write_deferred", uart_divisor, 32'd100);
    finish_chk(3);

    // Reset in the middle of SEND
    req = 4'b0100;
    grant_chk(2, 8'h32, 32'(DEF_DIV));
    req = '0;
    tick();
    tick();
    areset_n = 1'b0;
    #1;
    chk("mid_rst_start", 32'(uart_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_div", uart_divisor, 32'(DEF_DIV));
    tick();
    areset_n = 1'b1;
    req = 4'b1111;
    grant_chk(0, 8'h10, 32'(DEF_DIV));
    req = '0;
    finish_chk(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
